// File: rtl/sr_bridge_receiver.sv
// Slave-side deserializer for the dynamic/static shift-register link: oversamples
// SCLK/SEL/MOSI on CLK and delivers each completed word with a one-cycle valid strobe.
//
// state   | meaning
// IDLE    | line idle, waiting for the first SEL=1 sample
// DYN_RX  | collecting the dynamic word (SEL=1 samples)
// STAT_RX | collecting the static word (SEL=0 samples)
// DONE    | full frame received, samples ignored until RST
module sr_bridge_receiver #(
    parameter int SIZESRDYN      = 16,
    parameter int SIZESRSTAT     = 88,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  SCLK_IN,
    input  logic                  SEL_IN,
    input  logic                  MOSI_IN,
    output logic [SIZESRDYN-1:0]  DYN_REG,
    output logic [SIZESRSTAT-1:0] STAT_REG,
    output logic                  DYN_VALID,
    output logic                  STAT_VALID,
    output logic                  DONE,
    output logic                  BUSY,
    output logic                  FRAME_ERR
);
    localparam int CW = $clog2(SIZESRSTAT + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] DYN_LAST  = CW'(SIZESRDYN - 1);
    localparam logic [CW-1:0] STAT_LAST = CW'(SIZESRSTAT - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DYN_RX  = 2'd1,
        S_STAT_RX = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0]  sel_sync_q, sel_sync_d;
    logic [SYNC_STAGES-1:0]  mosi_sync_q, mosi_sync_d;
    logic                    sclk_dly_q, sclk_dly_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [TW-1:0]           to_cnt_q, to_cnt_d;
    logic [SIZESRDYN-1:0]    dyn_sh_q, dyn_sh_d;
    logic [SIZESRSTAT-1:0]   stat_sh_q, stat_sh_d;
    logic [SIZESRDYN-1:0]    dyn_reg_q, dyn_reg_d;
    logic [SIZESRSTAT-1:0]   stat_reg_q, stat_reg_d;
    logic                    dyn_valid_q, dyn_valid_d;
    logic                    stat_valid_q, stat_valid_d;
    logic                    frame_err_q, frame_err_d;

    logic                    sclk_s, sel_s, mosi_s, sample;
    logic [SIZESRDYN-1:0]    dyn_word;
    logic [SIZESRSTAT-1:0]   stat_word;
    logic [TW-1:0]           to_cnt_nxt;

    assign sclk_s     = sclk_sync_q[SYNC_STAGES-1];
    assign sel_s      = sel_sync_q[SYNC_STAGES-1];
    assign mosi_s     = mosi_sync_q[SYNC_STAGES-1];
    assign sample     = sclk_s & ~sclk_dly_q;
    assign dyn_word   = {dyn_sh_q[SIZESRDYN-2:0], mosi_s};
    assign stat_word  = {stat_sh_q[SIZESRSTAT-2:0], mosi_s};
    assign to_cnt_nxt = to_cnt_q + TW'(1);

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], SCLK_IN};
        sel_sync_d  = {sel_sync_q[SYNC_STAGES-2:0], SEL_IN};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI_IN};
        sclk_dly_d  = sclk_s;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        to_cnt_d     = to_cnt_q;
        dyn_sh_d     = dyn_sh_q;
        stat_sh_d    = stat_sh_q;
        dyn_reg_d    = dyn_reg_q;
        stat_reg_d   = stat_reg_q;
        dyn_valid_d  = 1'b0;
        stat_valid_d = 1'b0;
        frame_err_d  = frame_err_q;

        case (state_q)
            S_IDLE: begin
                to_cnt_d = '0;
                if (sample && sel_s) begin
                    dyn_sh_d    = dyn_word;
                    cnt_d       = CW'(1);
                    frame_err_d = 1'b0;
                    state_d     = S_DYN_RX;
                end
            end
            S_DYN_RX: begin
                if (sample) begin
                    to_cnt_d = '0;
                    if (!sel_s) begin
                        frame_err_d = 1'b1;
                        cnt_d       = '0;
                        state_d     = S_IDLE;
                    end else begin
                        dyn_sh_d = dyn_word;
                        if (cnt_q == DYN_LAST) begin
                            dyn_reg_d   = dyn_word;
                            dyn_valid_d = 1'b1;
                            cnt_d       = '0;
                            state_d     = S_STAT_RX;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end else if (to_cnt_nxt == TO_LAST) begin
                    frame_err_d = 1'b1;
                    cnt_d       = '0;
                    to_cnt_d    = '0;
                    state_d     = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_nxt;
                end
            end
            S_STAT_RX: begin
                if (sample) begin
                    to_cnt_d = '0;
                    if (sel_s) begin
                        frame_err_d = 1'b1;
                        cnt_d       = '0;
                        state_d     = S_IDLE;
                    end else begin
                        stat_sh_d = stat_word;
                        if (cnt_q == STAT_LAST) begin
                            stat_reg_d   = stat_word;
                            stat_valid_d = 1'b1;
                            cnt_d        = '0;
                            state_d      = S_DONE;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end else if (to_cnt_nxt == TO_LAST) begin
                    frame_err_d = 1'b1;
                    cnt_d       = '0;
                    to_cnt_d    = '0;
                    state_d     = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_nxt;
                end
            end
            default: begin
                to_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= S_IDLE;
            sclk_sync_q  <= '0;
            sel_sync_q   <= '0;
            mosi_sync_q  <= '0;
            sclk_dly_q   <= 1'b0;
            cnt_q        <= '0;
            to_cnt_q     <= '0;
            dyn_sh_q     <= '0;
            stat_sh_q    <= '0;
            dyn_reg_q    <= '0;
            stat_reg_q   <= '0;
            dyn_valid_q  <= 1'b0;
            stat_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sclk_sync_q  <= sclk_sync_d;
            sel_sync_q   <= sel_sync_d;
            mosi_sync_q  <= mosi_sync_d;
            sclk_dly_q   <= sclk_dly_d;
            cnt_q        <= cnt_d;
            to_cnt_q     <= to_cnt_d;
            dyn_sh_q     <= dyn_sh_d;
            stat_sh_q    <= stat_sh_d;
            dyn_reg_q    <= dyn_reg_d;
            stat_reg_q   <= stat_reg_d;
            dyn_valid_q  <= dyn_valid_d;
            stat_valid_q <= stat_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign DYN_REG    = dyn_reg_q;
    assign STAT_REG   = stat_reg_q;
    assign DYN_VALID  = dyn_valid_q;
    assign STAT_VALID = stat_valid_q;
    assign DONE       = (state_q == S_DONE);
    assign BUSY       = (state_q == S_DYN_RX) || (state_q == S_STAT_RX);
    assign FRAME_ERR  = frame_err_q;

endmodule

// File: tb/tb_sr_bridge_receiver.sv
// Directed bench for sr_bridge_receiver; word deliveries are checked by a
// scoreboard monitor, status outputs by directed checks in the stimulus thread.
module tb_sr_bridge_receiver;
    localparam int ND = 16;
    localparam int NS = 88;
    localparam logic [ND-1:0] DYN_NOM  = 16'hABC6;
    localparam logic [NS-1:0] STAT_NOM = 88'h123456789ABCDEF1234567;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          SCLK_IN = 1'b0;
    logic          SEL_IN = 1'b0;
    logic          MOSI_IN = 1'b0;
    logic [ND-1:0] DYN_REG;
    logic [NS-1:0] STAT_REG;
    logic          DYN_VALID, STAT_VALID, DONE, BUSY, FRAME_ERR;

    int checks = 0;
    int errors = 0;
    logic [ND-1:0] exp_dyn[$];
    logic [NS-1:0] exp_stat[$];

    sr_bridge_receiver #(
        .SIZESRDYN(ND), .SIZESRSTAT(NS), .SYNC_STAGES(2), .TIMEOUT_CYCLES(64)
    ) dut (
        .CLK(CLK), .RST(RST), .SCLK_IN(SCLK_IN), .SEL_IN(SEL_IN), .MOSI_IN(MOSI_IN),
        .DYN_REG(DYN_REG), .STAT_REG(STAT_REG), .DYN_VALID(DYN_VALID),
        .STAT_VALID(STAT_VALID), .DONE(DONE), .BUSY(BUSY), .FRAME_ERR(FRAME_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (DYN_VALID && STAT_VALID) check("valid_overlap", 1'b1, 1'b0);
        if (DYN_VALID) begin
            if (exp_dyn.size() == 0) check("unexpected_dyn_valid", DYN_REG, 128'hx);
            else check("dyn_word", DYN_REG, exp_dyn.pop_front());
        end
        if (STAT_VALID) begin
            if (exp_stat.size() == 0) check("unexpected_stat_valid", STAT_REG, 128'hx);
            else check("stat_word", STAT_REG, exp_stat.pop_front());
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // One serial bit, 40 CLK period: data 4 cycles ahead, 20 high, 16 low.
    task automatic send_bit(input logic sel, input logic mosi);
        @(posedge CLK); #1;
        SEL_IN = sel; MOSI_IN = mosi;
        cycles(4);
        SCLK_IN = 1'b1;
        cycles(20);
        SCLK_IN = 1'b0;
        cycles(15);
    endtask

    task automatic send_bits(input logic sel, input logic [127:0] val, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(sel, val[i]);
    endtask

    task automatic send_frame(input logic [ND-1:0] d, input logic [NS-1:0] s);
        exp_dyn.push_back(d);
        exp_stat.push_back(s);
        send_bits(1'b1, 128'(d), ND);
        send_bits(1'b0, 128'(s), NS);
        cycles(5);
    endtask

    task automatic do_reset();
        @(posedge CLK); #1;
        RST = 1'b1;
        cycles(2);
        RST = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dyn_reg"}, DYN_REG, 0);
        check({tag, "_stat_reg"}, STAT_REG, 0);
        check({tag, "_dyn_valid"}, DYN_VALID, 0);
        check({tag, "_stat_valid"}, STAT_VALID, 0);
        check({tag, "_done"}, DONE, 0);
        check({tag, "_busy"}, BUSY, 0);
        check({tag, "_frame_err"}, FRAME_ERR, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks + 1, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NS-1:0] stat_alt;
        stat_alt = 88'hFEDCBA9876543210FEDCBA;

        // Reset values
        cycles(3);
        RST = 1'b0;
        cycles(1);
        check_all_zero("reset");

        // Idle noise then nominal frame
        send_bits(1'b0, 128'h7, 3);
        check("idle_busy", BUSY, 0);
        check("idle_err", FRAME_ERR, 0);
        exp_dyn.push_back(DYN_NOM);
        exp_stat.push_back(STAT_NOM);
        send_bits(1'b1, 128'(DYN_NOM), ND);
        check("mid_busy", BUSY, 1);
        check("mid_dyn_reg", DYN_REG, 128'(DYN_NOM));
        send_bits(1'b0, 128'(STAT_NOM), NS);
        cycles(5);
        check("nom_dyn_reg", DYN_REG, 128'(DYN_NOM));
        check("nom_stat_reg", STAT_REG, 128'(STAT_NOM));
        check("nom_done", DONE, 1);
        check("nom_busy", BUSY, 0);
        check("nom_err", FRAME_ERR, 0);

        // DONE lock: extra edges with SEL=1, MOSI=1 are ignored
        send_bits(1'b1, {128{1'b1}}, 20);
        check("lock_dyn_reg", DYN_REG, 128'(DYN_NOM));
        check("lock_stat_reg", STAT_REG, 128'(STAT_NOM));
        check("lock_done", DONE, 1);
        check("lock_err", FRAME_ERR, 0);

        // Short dynamic word
        do_reset();
        send_bits(1'b1, 128'h3A5, 10);
        check("short_busy_before", BUSY, 1);
        send_bits(1'b0, 128'h0, 2);
        check("short_err", FRAME_ERR, 1);
        check("short_busy", BUSY, 0);
        check("short_done", DONE, 0);
        check("short_dyn_reg", DYN_REG, 0);

        // Recovery: first SEL=1 sample clears the error
        exp_dyn.push_back(DYN_NOM);
        exp_stat.push_back(STAT_NOM);
        send_bit(1'b1, DYN_NOM[ND-1]);
        check("recov_err_cleared", FRAME_ERR, 0);
        check("recov_busy", BUSY, 1);
        send_bits(1'b1, 128'(DYN_NOM), ND - 1);
        send_bits(1'b0, 128'(STAT_NOM), NS);
        cycles(5);
        check("recov_dyn_reg", DYN_REG, 128'(DYN_NOM));
        check("recov_stat_reg", STAT_REG, 128'(STAT_NOM));
        check("recov_done", DONE, 1);

        // Reset pulse during static bit 50
        do_reset();
        exp_dyn.push_back(16'h1357);
        send_bits(1'b1, 128'h1357, ND);
        send_bits(1'b0, 128'(STAT_NOM >> (NS - 49)), 49);
        @(posedge CLK); #1;
        SEL_IN = 1'b0; MOSI_IN = 1'b1;
        cycles(4);
        SCLK_IN = 1'b1;
        cycles(8);
        RST = 1'b1;
        cycles(1);
        RST = 1'b0;
        check_all_zero("rst_mid");
        cycles(12);
        SCLK_IN = 1'b0;
        cycles(15);
        check("rst_mid_idle_busy", BUSY, 0);
        send_frame(16'h8001, stat_alt);
        check("post_rst_dyn_reg", DYN_REG, 128'h8001);
        check("post_rst_stat_reg", STAT_REG, 128'(stat_alt));
        check("post_rst_done", DONE, 1);

        // Timeout after 40 static bits: error 63 edges after the last sample edge
        do_reset();
        exp_dyn.push_back(DYN_NOM);
        send_bits(1'b1, 128'(DYN_NOM), ND);
        send_bits(1'b0, 128'(STAT_NOM >> (NS - 39)), 39);
        @(posedge CLK); #1;
        SEL_IN = 1'b0; MOSI_IN = 1'b0;
        cycles(4);
        SCLK_IN = 1'b1;
        for (int i = 1; i <= 66; i++) begin
            @(posedge CLK); #1;
            if (i == 20) SCLK_IN = 1'b0;
            if (i == 65) check("timeout_not_yet", FRAME_ERR, 0);
            if (i == 66) check("timeout_err", FRAME_ERR, 1);
        end
        check("timeout_busy", BUSY, 0);
        check("timeout_stat_reg", STAT_REG, 0);
        check("timeout_dyn_reg", DYN_REG, 128'(DYN_NOM));

        // Recovery after timeout
        send_bit(1'b1, DYN_NOM[ND-1]);
        check("to_recov_err_cleared", FRAME_ERR, 0);
        exp_dyn.push_back(DYN_NOM);
        exp_stat.push_back(STAT_NOM);
        send_bits(1'b1, 128'(DYN_NOM), ND - 1);
        send_bits(1'b0, 128'(STAT_NOM), NS);
        cycles(5);
        check("to_recov_stat_reg", STAT_REG, 128'(STAT_NOM));
        check("to_recov_done", DONE, 1);

        check("dyn_queue_drained", 128'(exp_dyn.size()), 0);
        check("stat_queue_drained", 128'(exp_stat.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sr_bridge_receiver.md
# sr_bridge_receiver

Slave-side deserializer for the static/dynamic shift-register configuration link. It oversamples the forwarded serial clock, select and data lines with the fast system clock and rebuilds the 16-bit dynamic word, then the 88-bit static word. Each completed word is presented on parallel outputs with a one-cycle valid strobe. The block sits on the ASIC side of the bridge, opposite the configuration FSM that drives `SEL`, `MOSI` and the gated `CLK_uC`.

## Interface
- `SIZESRDYN`, 16: dynamic word length in bits.
- `SIZESRSTAT`, 88: static word length in bits.
- `SYNC_STAGES`, 2: synchronizer depth on each serial input; must be ≥2.
- `TIMEOUT_CYCLES`, 4096: maximum `CLK` cycles allowed between serial clock rising edges inside a frame.

- `CLK`  in  1  fast system clock. Single clock domain: one clock; reset is synchronous and active-high.
- `RST`  in  1  synchronous, active-high reset.
- `SCLK_IN`  in  1  forwarded serial clock (gated `CLK_uC`), asynchronous to `CLK`.
- `SEL_IN`  in  1  register select: 1 = dynamic bit, 0 = static bit.
- `MOSI_IN`  in  1  serial data, MSB first.
- `DYN_REG`  out  SIZESRDYN  last completed dynamic word.
- `STAT_REG`  out  SIZESRSTAT  last completed static word.
- `DYN_VALID`  out  1  one-cycle strobe when `DYN_REG` updates.
- `STAT_VALID`  out  1  one-cycle strobe when `STAT_REG` updates.
- `DONE`  out  1  high once a full dynamic plus static frame has been received.
- `BUSY`  out  1  high in DYN_RX or STAT_RX.
- `FRAME_ERR`  out  1  sticky framing or timeout error flag.

## Operation
- Each of `SCLK_IN`, `SEL_IN` and `MOSI_IN` passes through an identical `SYNC_STAGES`-deep flop chain. One more flop on the synchronized serial clock provides rising-edge detection.
- A sample event is a cycle where the synchronized serial clock is 1 and its delayed copy is 0. On that cycle the synchronized `SEL` and `MOSI` are taken as one bit.
- Shifting: `sh <= {sh[N-2:0], mosi}`, MSB first. There are separate dynamic and static shifters. The bit counter is wide enough for `SIZESRSTAT`.
- FSM states and transitions:
  - IDLE:
    - Sample with SEL=1: the bit goes into the dynamic shifter, count=1, go to DYN_RX, and clear `FRAME_ERR`.
    - Sample with SEL=0: ignored. This is the line-idle level.
  - DYN_RX:
    - Sample with SEL=1: shift and increment the count.
    - On the `SIZESRDYN`-th bit: `DYN_REG` is loaded with the full word, `DYN_VALID` pulses, count=0, go to STAT_RX.
    - Sample with SEL=0 before `SIZESRDYN` bits: set `FRAME_ERR`, go to IDLE. `DYN_REG` is unchanged.
  - STAT_RX:
    - Sample with SEL=0: shift and increment the count.
    - On the `SIZESRSTAT`-th bit: `STAT_REG` is loaded, `STAT_VALID` pulses, go to DONE.
    - Sample with SEL=1: set `FRAME_ERR`, go to IDLE. `STAT_REG` is unchanged.
  - DONE: `DONE`=1. All samples are ignored. The block leaves DONE only on `RST`.
- Timeout: in DYN_RX or STAT_RX, a counter clears on every sample event and otherwise increments. If it reaches `TIMEOUT_CYCLES-1`: set `FRAME_ERR`, go to IDLE, and leave partial data undelivered.
- Partial shifter contents are never visible on `DYN_REG` or `STAT_REG`.

## Timing
- Reset values:
  - `DYN_REG`=0, `STAT_REG`=0.
  - `DYN_VALID`, `STAT_VALID`, `DONE`, `BUSY`, `FRAME_ERR` all 0.
  - FSM in IDLE; synchronizers, edge flop, shifters and counters all 0.
- `RST` asserted mid-frame: all of the above apply on the next `CLK` edge, and the partial frame is discarded.
- Latency: the sample event occurs `SYNC_STAGES`+1 `CLK` cycles after `SCLK_IN` rises.
- On the sample event of the last bit, the `CLK` edge that follows loads `DYN_REG`/`STAT_REG` and asserts `*_VALID` for exactly one cycle. `BUSY`/`DONE` change on the same edge.
- `DYN_VALID` and `STAT_VALID` are never high together. At least one serial period separates them.
- Input requirements:
  - `SCLK_IN` high and low phases each ≥ `SYNC_STAGES`+2 `CLK` periods.
  - `SEL_IN`/`MOSI_IN` stable from ≥2 `CLK` periods before the `SCLK_IN` rise until ≥2 periods after it.
  - The upstream delayed forwarded clock meets these requirements.
- Simultaneous events: if a timeout and a sample event occur on the same cycle, the sample wins and the timeout counter clears.

## Test plan
- Nominal frame:
  - Stimulus: 16 bits of 16'hABC6 with SEL=1, then 88 bits of 88'h123456789ABCDEF1234567 with SEL=0, serial period 40 `CLK`.
  - Required: `DYN_REG`=16'hABC6 with one `DYN_VALID` pulse; `STAT_REG`=88'h123456789ABCDEF1234567 with one `STAT_VALID` pulse; `DONE`=1; `FRAME_ERR`=0.
- Short dynamic word:
  - Stimulus: 10 bits with SEL=1, then SEL=0 edges.
  - Required: `FRAME_ERR`=1, FSM in IDLE, `DYN_REG` keeps its prior value, no `DYN_VALID`.
- Timeout:
  - Stimulus: 40 static bits, then `SCLK_IN` held low with `TIMEOUT_CYCLES`=64.
  - Required: `FRAME_ERR` rises 63 cycles after the last sample event; `BUSY`=0; no `STAT_VALID`.
- Recovery after error:
  - Stimulus: the error case above, followed by the nominal frame.
  - Required: `FRAME_ERR` clears on the first SEL=1 sample; final registers match the nominal values.
- Reset mid-frame:
  - Stimulus: `RST` pulsed for 1 cycle during static bit 50.
  - Required: all outputs are 0 on the next cycle; a subsequent full frame decodes correctly.
- DONE lock and idle noise:
  - Stimulus: SEL=0 edges in IDLE, then a nominal frame, then 20 extra edges with SEL=1 and `MOSI_IN`=1.
  - Required: idle edges are ignored; after DONE, `DYN_REG`/`STAT_REG` are unchanged and no valid strobes occur.
